nibble_serial_accumulator: RTL and testbench
============================================

Name: nibble_serial_accumulator

Overview:
- Running-sum accumulator built around one shared 4-bit ripple adder (no carry-in, carry-out only).
- Accepts 4-bit operands through a valid/ready handshake and adds each one into a 4*NIBBLES-bit accumulator, one nibble per clock, propagating the carry between nibbles.
- Feeds the adder its x/y operands and consumes its sum/carry, so it sits directly upstream and downstream of the adder stage.

Parameters:
- NIBBLES, 2, accumulator width in nibbles; ACC_W = 4*NIBBLES; legal range 2..8.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand offered.
- in_ready  output  1  block can accept an operand this cycle.
- in_data  input  4  unsigned operand.
- clear  input  1  synchronous clear of accumulator and overflow.
- acc_out  output  ACC_W  accumulator value, registered.
- done  output  1  one-cycle pulse, acc_out holds the newly updated sum.
- overflow  output  1  sticky flag: some add carried out of the MSB nibble.

Behaviour:
- Reset (rst=1 at clock edge):
  - state=IDLE, acc_out=0, overflow=0, done=0, nibble index=0, carry reg=0.
  - in_ready is 0 while rst=1.
- Handshake:
  - in_ready = (state==IDLE) && !clear && !rst.
  - Transfer occurs on a clock edge with in_valid && in_ready.
  - in_data is latched into an operand register. in_data is ignored outside a transfer.
- FSM with states IDLE and ADD:
  - IDLE: on transfer go to ADD with idx=0.
  - ADD: each cycle drive adder x = acc[4*idx+3 : 4*idx], y = (idx==0) ? operand : {3'b000, carry_reg}.
    - On the edge: acc nibble idx <= s, carry_reg <= c4.
    - If idx==NIBBLES-1: go to IDLE, overflow <= overflow | c4, done <= 1 (visible the cycle after the last ADD).
    - Else idx <= idx+1.
- Latency:
  - Transfer at edge T; final acc_out and done visible after edge T+NIBBLES.
  - Throughput is one operand per NIBBLES+1 cycles; in_ready returns high in the same cycle done is high.
- Fixed latency: all NIBBLES steps always execute, even when the carry is 0. No early exit.
- Width and wrap:
  - Result is (acc + in_data) mod 2^ACC_W.
  - Upper nibbles are partially updated mid-operation; acc_out is only architecturally valid when done=1 or state==IDLE.
- clear:
  - Priority is rst > clear > everything else.
  - Effect: acc_out=0, overflow=0, state=IDLE, idx=0, carry_reg=0, done=0.
  - clear during ADD aborts the operation. The operand is dropped and no done pulse occurs.
  - clear with in_valid in IDLE: no transfer, because in_ready is 0.
- done is 0 in every cycle except the single pulse. overflow stays high until rst or clear.

Decomposition:
- Shared package:
  - FSM state enum (IDLE, ADD).
  - Localparam ACC_W.
  - Index width constant IDX_W = clog2(NIBBLES).
- One sub-module: the existing structural 4-bit ripple adder (Four_Bit_Adder_Struc). Instantiate it exactly once, with the nibble mux on its inputs.
- No second adder, and no behavioural '+' on the datapath.

Test Plan (NIBBLES=2 unless stated):
- Reset: hold rst 2 cycles, then release -> acc_out=0x00, overflow=0, done=0, in_ready=1 in the first cycle after release.
- Basic add: send 4'hF, then 4'hF again after done.
  - acc_out=0x0F with done 2 cycles after the first transfer.
  - Then acc_out=0x1E; high-nibble carry is exercised, overflow=0.
- Wrap/overflow: 17 transfers of 4'hF (acc=0xFF), then 4'h1.
  - acc_out=0x00, done pulses, overflow=1.
  - A further 4'h2 gives acc_out=0x02 and overflow stays 1.
- Back-to-back: in_valid held high with data 1,2,3,4.
  - Transfers exactly every 3 cycles.
  - done pulses show acc_out=0x01, 0x03, 0x06, 0x0A.
  - in_ready is low during ADD cycles.
- Clear mid-operation: acc=0x1E, transfer 4'h5, assert clear in the first ADD cycle.
  - Next cycle: acc_out=0x00, overflow=0, no done pulse, in_ready=1.
- Clear vs. valid and reset mid-op:
  - clear=1 with in_valid=1 in IDLE -> no transfer, acc_out=0.
  - With NIBBLES=4: assert rst during ADD idx=2 -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/nibble_serial_accumulator_pkg.sv
// Shared types and sizing helpers for the nibble-serial accumulator.
// The *_DEF constants describe the default two-nibble build; instances derive their own widths from NIBBLES.
package nibble_serial_accumulator_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ADD  = 1'b1
  } state_t;

  localparam int NIBBLES_DEF = 2;
  localparam int ACC_W       = 4 * NIBBLES_DEF;
  localparam int IDX_W       = $clog2(NIBBLES_DEF);

  function automatic int acc_w_of(input int nibbles);
    return 4 * nibbles;
  endfunction

  // Keep the nibble index at least one bit wide.
  function automatic int idx_w_of(input int nibbles);
    return (nibbles < 2) ? 1 : $clog2(nibbles);
  endfunction

endpackage

// File: rtl/nibble_serial_accumulator_adder.sv
// Structural 4-bit ripple-carry adder with no carry-in.
// Each bit is a propagate/generate full-adder cell.
module Four_Bit_Adder_Struc (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [3:0] s,
  output logic       c4
);

  wire [4:0] c;
  assign c[0] = 1'b0;

  genvar i;
  generate
    for (i = 0; i < 4; i++) begin : g_fa
      wire p;
      wire g;
      wire pc;
      assign p        = x[i] ^ y[i];
      assign g        = x[i] & y[i];
      assign pc       = p & c[i];
      assign s[i]     = p ^ c[i];
      assign c[i + 1] = g | pc;
    end
  endgenerate

  assign c4 = c[4];

endmodule

// File: rtl/nibble_serial_accumulator.sv
// Running-sum accumulator that adds 4-bit operands into a NIBBLES-wide register,
// one nibble per clock, through a single shared 4-bit ripple adder.
module nibble_serial_accumulator
  import nibble_serial_accumulator_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_data,
  input  logic                   clear,
  output logic [4*NIBBLES-1:0]   acc_out,
  output logic                   done,
  output logic                   overflow,
  output state_t                 state_dbg
);

  localparam int AW = acc_w_of(NIBBLES);
  localparam int IW = idx_w_of(NIBBLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  state_t          state;
  state_t          state_next;
  logic [IW-1:0]   idx;
  logic            carry_reg;
  logic [3:0]      operand;
  logic [AW-1:0]   acc;
  logic [AW-1:0]   acc_upd;
  logic [3:0]      add_x;
  logic [3:0]      add_y;
  logic [3:0]      add_s;
  logic            add_c4;
  logic            xfer;
  logic            last_step;

  // Handshake: an operand transfers on any rising edge where in_valid && in_ready;
  // in_ready is only offered in IDLE, and never while rst or clear is asserted.
  assign in_ready  = (state == IDLE) && !clear && !rst;
  assign xfer      = in_valid && in_ready;
  assign last_step = (state == ADD) && (idx == LAST_IDX);

  always_comb begin
    add_x   = '0;
    acc_upd = acc;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IW'(i)) begin
        add_x                = acc[4*i +: 4];
        acc_upd[4*i +: 4]    = add_s;
      end
    end
    add_y = (idx == '0) ? operand : {3'b000, carry_reg};
  end

  Four_Bit_Adder_Struc u_adder (
    .x  (add_x),
    .y  (add_y),
    .s  (add_s),
    .c4 (add_c4)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (xfer) state_next = ADD;
      ADD:     if (last_step) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state     <= IDLE;
      idx       <= '0;
      carry_reg <= 1'b0;
      operand   <= '0;
      acc       <= '0;
      overflow  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_next;
      done  <= last_step;
      if (xfer) begin
        operand <= in_data;
        idx     <= '0;
      end
      // Every nibble step runs even when the carry is zero, so latency is fixed.
      if (state == ADD) begin
        acc       <= acc_upd;
        carry_reg <= add_c4;
        if (last_step) begin
          overflow <= overflow | add_c4;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

  assign acc_out   = acc;
  assign state_dbg = state;

endmodule

// File: tb/tb_nibble_serial_accumulator.sv
// Bench for nibble_serial_accumulator: a two-nibble instance for the main tests
// and a four-nibble instance for the reset-during-add case.
module tb_nibble_serial_accumulator;
  import nibble_serial_accumulator_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, clear;
  logic [3:0]   in_data;
  logic         in_ready, done, overflow;
  logic [7:0]   acc_out;
  state_t       st2;

  logic         rst4, iv4, clr4;
  logic [3:0]   id4;
  logic         ir4, done4, ovf4;
  logic [15:0]  acc4;
  state_t       st4;

  nibble_serial_accumulator #(.NIBBLES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .clear(clear), .acc_out(acc_out), .done(done), .overflow(overflow), .state_dbg(st2)
  );

  nibble_serial_accumulator #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst(rst4), .in_valid(iv4), .in_ready(ir4), .in_data(id4),
    .clear(clr4), .acc_out(acc4), .done(done4), .overflow(ovf4), .state_dbg(st4)
  );

  // ---------------- scoreboard / model ----------------
  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] m_acc = '0;
  logic       m_ovf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_add(input logic [3:0] d);
    int unsigned s;
    s = int'(m_acc) + int'(d);
    if (s > 255) m_ovf = 1'b1;
    m_acc = 8'(s % 256);
  endtask

  // ---------------- drivers ----------------
  task automatic op2(input logic [3:0] d);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    in_data = 4'($urandom_range(0, 15));
    model_add(d);
    n = 0;
    while (n < 12) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    chk("done_latency", n, 32'd3);
    chk("acc", {24'd0, acc_out}, {24'd0, m_acc});
    chk("ovf", {31'd0, overflow}, {31'd0, m_ovf});
    chk("ready_with_done", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  task automatic clear2();
    @(negedge clk);
    clear = 1'b1;
    #1 chk("ready_in_clear", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1 clear = 1'b0;
    m_acc = '0;
    m_ovf = 1'b0;
  endtask

  task automatic op4(input logic [3:0] d, input logic [15:0] exp);
    int n;
    @(negedge clk);
    iv4 = 1'b1;
    id4 = d;
    chk("ready4", {31'd0, ir4}, 32'd1);
    @(posedge clk);
    #1 iv4 = 1'b0;
    n = 0;
    while (n < 12) begin
      @(negedge clk);
      n++;
      if (done4) break;
    end
    chk("done4_latency", n, 32'd5);
    chk("acc4", {16'd0, acc4}, {16'd0, exp});
  endtask

  typedef struct {
    logic [3:0] d;
    logic [7:0] acc;
    logic       ovf;
  } vec_t;
  vec_t tbl[6];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int k, last, ndone, cnt;
    logic [3:0] vals[4];
    logic [7:0] e;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; clear = 1'b0;
    rst4 = 1'b1; iv4 = 1'b0; id4 = '0; clr4 = 1'b0;

    // Reset: two cycles held, then release.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_acc", {24'd0, acc_out}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    rst4 = 1'b0;
    #1 chk("ready_after_rst", {31'd0, in_ready}, 32'd1);

    // Table-driven vectors, starting from a zero accumulator.
    tbl[0] = '{4'hF, 8'h0F, 1'b0};
    tbl[1] = '{4'hF, 8'h1E, 1'b0};
    tbl[2] = '{4'h1, 8'h1F, 1'b0};
    tbl[3] = '{4'h8, 8'h27, 1'b0};
    tbl[4] = '{4'h9, 8'h30, 1'b0};
    tbl[5] = '{4'h0, 8'h30, 1'b0};
    for (int i = 0; i < 6; i++) begin
      op2(tbl[i].d);
      chk("tbl_acc", {24'd0, acc_out}, {24'd0, tbl[i].acc});
      chk("tbl_ovf", {31'd0, overflow}, {31'd0, tbl[i].ovf});
    end

    // Wrap and sticky overflow.
    clear2();
    repeat (17) op2(4'hF);
    chk("wrap_pre", {24'd0, acc_out}, 32'hFF);
    op2(4'h1);
    chk("wrap_acc", {24'd0, acc_out}, 32'h00);
    chk("wrap_ovf", {31'd0, overflow}, 32'd1);
    op2(4'h2);
    chk("wrap2_acc", {24'd0, acc_out}, 32'h02);
    chk("wrap2_ovf", {31'd0, overflow}, 32'd1);

    // Back-to-back with in_valid held high.
    clear2();
    vals[0] = 4'd1; vals[1] = 4'd2; vals[2] = 4'd3; vals[3] = 4'd4;
    k = 0; last = -1; ndone = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
        chk("b2b_acc", {24'd0, acc_out}, {24'd0, e});
      end
      if (st2 == ADD) chk("b2b_ready_low", {31'd0, in_ready}, 32'd0);
      if (in_ready) begin
        if (k < 4) begin
          in_valid = 1'b1;
          in_data  = vals[k];
          model_add(vals[k]);
          exp_q.push_back(m_acc);
          if (last >= 0) chk("b2b_spacing", cyc - last, 32'd3);
          last = cyc;
          k++;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    chk("b2b_ndone", ndone, 32'd4);
    chk("b2b_final", {24'd0, acc_out}, 32'h0A);

    // Clear during the first ADD cycle aborts the operation.
    clear2();
    op2(4'hF);
    op2(4'hF);
    chk("pre_clr_acc", {24'd0, acc_out}, 32'h1E);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 4'h5;
    chk("clr_xfer_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("clr_in_add", {31'd0, st2}, {31'd0, ADD});
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    m_acc = '0; m_ovf = 1'b0;
    @(negedge clk);
    chk("clr_acc", {24'd0, acc_out}, 32'd0);
    chk("clr_ovf", {31'd0, overflow}, 32'd0);
    chk("clr_done", {31'd0, done}, 32'd0);
    chk("clr_ready", {31'd0, in_ready}, 32'd1);
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("clr_no_done", cnt, 32'd0);

    // Clear together with in_valid in IDLE: no transfer.
    op2(4'h3);
    @(negedge clk);
    clear = 1'b1; in_valid = 1'b1; in_data = 4'h7;
    #1 chk("clrv_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1 clear = 1'b0; in_valid = 1'b0;
    m_acc = '0; m_ovf = 1'b0;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || acc_out != 8'h00) cnt++;
    end
    chk("clrv_no_xfer", cnt, 32'd0);
    chk("clrv_idle", {31'd0, st2}, {31'd0, IDLE});

    // Randomized operands with occasional clears, against the model.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 15) == 0) clear2();
      else op2(4'($urandom_range(0, 15)));
    end

    // Four-nibble instance: reset while idx==2.
    op4(4'hF, 16'h000F);
    op4(4'hF, 16'h001E);
    @(negedge clk);
    iv4 = 1'b1; id4 = 4'h3;
    @(posedge clk);
    #1 iv4 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst4_in_add", {31'd0, st4}, {31'd0, ADD});
    rst4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst4_acc", {16'd0, acc4}, 32'd0);
    chk("rst4_ovf", {31'd0, ovf4}, 32'd0);
    chk("rst4_done", {31'd0, done4}, 32'd0);
    chk("rst4_ready", {31'd0, ir4}, 32'd0);
    chk("rst4_state", {31'd0, st4}, {31'd0, IDLE});
    rst4 = 1'b0;
    #1 chk("rst4_ready_rel", {31'd0, ir4}, 32'd1);
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (done4) cnt++;
    end
    chk("rst4_no_done", cnt, 32'd0);
    op4(4'h9, 16'h0009);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
